// File: rtl/pid_fixed_pkg.sv
// Fixed-point constants and word types shared by the PI controller and its PWM driver.
// Q-format: 1.0 is represented as FP_ONE = 2^Q.
`timescale 1ns/1ps
package pid_fixed_pkg;
  localparam int N = 32;
  localparam int Q = 18;
  localparam logic [N-1:0] FP_ONE = N'(1) << Q;

  typedef logic signed [N-1:0]   fp_word_t;
  typedef logic signed [2*N-1:0] fp_prod_t;
endpackage

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM outputs with a DEAD-cycle both-low gap after every raw edge.
// Only instantiated when PWM_DEADTIME_EN is defined.
`timescale 1ns/1ps
module pwm_deadtime_gen #(
  parameter int DEAD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  output logic pwm_out,
  output logic pwm_out_n
);
  localparam int DW = $clog2(DEAD + 1);

  logic          raw_prev_reg;
  logic [DW-1:0] dead_reg;
  logic          hi_reg;
  logic          lo_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_prev_reg <= 1'b0;
      dead_reg     <= '0;
      hi_reg       <= 1'b0;
      lo_reg       <= 1'b0;
    end else begin
      raw_prev_reg <= raw;
      if (!enable) begin
        dead_reg <= '0;
        hi_reg   <= 1'b0;
        lo_reg   <= 1'b0;
      end else if (raw != raw_prev_reg) begin
        // The edge cycle itself is the first of the DEAD low cycles.
        dead_reg <= DW'(DEAD - 1);
        hi_reg   <= 1'b0;
        lo_reg   <= 1'b0;
      end else if (dead_reg != '0) begin
        dead_reg <= dead_reg - DW'(1);
        hi_reg   <= 1'b0;
        lo_reg   <= 1'b0;
      end else begin
        hi_reg <= raw;
        lo_reg <= ~raw;
      end
    end
  end

  assign pwm_out   = hi_reg;
  assign pwm_out_n = lo_reg;
endmodule

// File: rtl/pid_pwm_driver.sv
// Converts the signed Q-format PI output to a boundary-synchronous PWM with dir/sat flags.
// Define PWM_DEADTIME_EN for complementary outputs with dead time (pwm_deadtime_gen).
`timescale 1ns/1ps
module pid_pwm_driver #(
  parameter int N      = pid_fixed_pkg::N,
  parameter int Q      = pid_fixed_pkg::Q,
  parameter int CNT_W  = 16,
  parameter int PERIOD = 1000,
  parameter int DEAD   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [N-1:0] data_in,
  input  logic                in_valid,
  input  logic                enable,
  output logic                pwm_out,
  output logic                pwm_out_n,
  output logic                dir,
  output logic                sat,
  output logic                period_start
);
  localparam int               MAG_W  = Q + 1;
  localparam int               PROD_W = MAG_W + CNT_W;
  localparam logic [N-1:0]     ONE    = N'(1) << Q;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);

  if (PERIOD < 2 || PERIOD >= (1 << CNT_W) || DEAD < 1) begin : g_bad_cfg
    $error("pid_pwm_driver: PERIOD, CNT_W or DEAD out of range");
  end

  logic [N-1:0]     abs_val;
  logic             over_one;
  logic [MAG_W-1:0] mag_reg;
  logic             neg_reg, sat1_reg, valid1_reg;
  logic [CNT_W-1:0] duty_pending_reg, duty_active_reg, cnt_reg;
  logic             dir_pending_reg, sat_pending_reg, pending_reg;
  logic             dir_reg, sat_reg, started_reg;
  logic             run, wrap, pwm_raw;

  // Unsigned magnitude: the most negative word maps to 2^(N-1) and then clamps.
  assign abs_val  = data_in[N-1] ? (~data_in + N'(1)) : data_in;
  assign over_one = abs_val > ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid1_reg <= 1'b0;
      neg_reg    <= 1'b0;
      sat1_reg   <= 1'b0;
      mag_reg    <= '0;
    end else begin
      valid1_reg <= in_valid;
      if (in_valid) begin
        neg_reg  <= data_in[N-1];
        sat1_reg <= over_one;
        mag_reg  <= over_one ? MAG_W'(ONE) : abs_val[MAG_W-1:0];
      end
    end
  end

  // started_reg keeps the counter parked at 0 for the first cycle after reset release.
  assign run          = enable && started_reg;
  assign wrap         = run && (cnt_reg == LAST);
  assign pwm_raw      = run && (cnt_reg < duty_active_reg);
  assign period_start = run && (cnt_reg == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_reg      <= 1'b0;
      duty_pending_reg <= '0;
      dir_pending_reg  <= 1'b0;
      sat_pending_reg  <= 1'b0;
      pending_reg      <= 1'b0;
      duty_active_reg  <= '0;
      dir_reg          <= 1'b0;
      sat_reg          <= 1'b0;
      cnt_reg          <= '0;
    end else begin
      started_reg <= 1'b1;
      // A new value arriving on the wrap edge stays pending; the old one is applied.
      if (valid1_reg) begin
        duty_pending_reg <= CNT_W'((PROD_W'(mag_reg) * PROD_W'(PERIOD)) >> Q);
        dir_pending_reg  <= neg_reg;
        sat_pending_reg  <= sat1_reg;
        pending_reg      <= 1'b1;
      end else if (wrap) begin
        pending_reg <= 1'b0;
      end
      if (wrap && pending_reg) begin
        duty_active_reg <= duty_pending_reg;
        dir_reg         <= dir_pending_reg;
        sat_reg         <= sat_pending_reg;
      end
      if (!run || wrap) cnt_reg <= '0;
      else              cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign dir = dir_reg;
  assign sat = sat_reg;

`ifdef PWM_DEADTIME_EN
  pwm_deadtime_gen #(
    .DEAD(DEAD)
  ) u_deadtime (
    .clk      (clk),
    .reset    (reset),
    .enable   (run),
    .raw      (pwm_raw),
    .pwm_out  (pwm_out),
    .pwm_out_n(pwm_out_n)
  );
`else
  logic pwm_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_reg <= 1'b0;
    else        pwm_reg <= pwm_raw;
  end

  assign pwm_out   = pwm_reg;
  assign pwm_out_n = 1'b0;
`endif
endmodule
